// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side adapters.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fifo_pkg;

    // Buffer occupancy; the encoding equals the number of words held.
    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ONE,
        OCC_TWO
    } occ_e;

    // Cycles from an accepted FIFO read to its data appearing on fifo_rd_data.
    localparam int FIFO_RD_LATENCY = 1;

endpackage

// File: rtl/fifo_rd_stream.sv
// FIFO read port to valid/ready stream adapter with a 2-entry head/skid buffer.
// Latency: fifo_rd_empty low at N -> read at N, data lands N+1, m_valid at N+2; 1 word/cycle sustained.
// Backpressure: m_ready low holds m_valid/m_data; reads stop once 2 words are held or in flight.
// Optional macro FIFO_RD_STREAM_STATS_EN adds the 32-bit pop_count port.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int BITS = 32
) (
    input  logic            rd_clk,
    input  logic            rd_rst_n,
    output logic            fifo_rd_en,
    input  logic            fifo_rd_empty,
    input  logic [BITS-1:0] fifo_rd_data,
    output logic            m_valid,
    input  logic            m_ready,
`ifdef FIFO_RD_STREAM_STATS_EN
    output logic [31:0]     pop_count,
`endif
    output logic [BITS-1:0] m_data
);

    // Slots needed to cover the read latency plus one held word at full rate.
    localparam int SLOTS = FIFO_RD_LATENCY + 1;

    occ_e            occ_q, occ_d;
    logic            inflight_q;
    logic            valid_q;
    logic [BITS-1:0] head_q, head_d;
    logic [BITS-1:0] skid_q, skid_d;
    logic            pop;
    logic            land;
    logic [2:0]      level;

    assign pop  = valid_q && m_ready;
    assign land = inflight_q;

    // Words held plus in flight after this cycle's pop; pop implies occ >= 1, so no underflow.
    assign level = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

    // m_ready reaches fifo_rd_en combinationally so a pop frees a slot in the same cycle.
    assign fifo_rd_en = rd_rst_n && !fifo_rd_empty && (level < 3'(SLOTS));

    assign m_valid = valid_q;
    assign m_data  = head_q;

    // Next buffer state from the (land, pop) pair; a landing word always finds a free slot.
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        skid_d = skid_q;
        case (occ_q)
            OCC_EMPTY: begin
                if (land) begin
                    occ_d  = OCC_ONE;
                    head_d = fifo_rd_data;
                end
            end
            OCC_ONE: begin
                if (land && pop) begin
                    head_d = fifo_rd_data;
                end else if (land) begin
                    occ_d  = OCC_TWO;
                    skid_d = fifo_rd_data;
                end else if (pop) begin
                    occ_d  = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                if (pop) begin
                    occ_d  = OCC_ONE;
                    head_d = skid_q;
                end
            end
            default: begin
                occ_d = OCC_EMPTY;
            end
        endcase
    end

    // Buffer registers, in-flight tracking and the registered valid flag.
    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            occ_q      <= OCC_EMPTY;
            inflight_q <= 1'b0;
            valid_q    <= 1'b0;
            head_q     <= '0;
            skid_q     <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= fifo_rd_en;
            valid_q    <= (occ_d != OCC_EMPTY);
            head_q     <= head_d;
            skid_q     <= skid_d;
        end
    end

`ifdef FIFO_RD_STREAM_STATS_EN
    logic [31:0] pop_count_q;

    // Count accepted stream words; wraps naturally at 32 bits.
    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            pop_count_q <= '0;
        end else if (pop) begin
            pop_count_q <= pop_count_q + 32'd1;
        end
    end

    assign pop_count = pop_count_q;
`endif

    // Held plus in-flight words never exceed the buffer depth.
    a_occ_bound: assert property (@(posedge rd_clk) disable iff (!rd_rst_n)
        ({1'b0, occ_q} + {2'b00, inflight_q}) <= 3'd2);

    // No word may land while both slots are full.
    a_no_land_full: assert property (@(posedge rd_clk) disable iff (!rd_rst_n)
        (occ_q == OCC_TWO) |-> !inflight_q);

    // A stalled word stays put until it is taken.
    a_hold_stable: assert property (@(posedge rd_clk) disable iff (!rd_rst_n)
        (m_valid && !m_ready) |=> (m_valid && $stable(m_data)));

endmodule
